contador_16b: RTL and testbench



---
 rtl/contador_pkg.sv | 14 +
 rtl/contador_tick_gen.sv | 32 +++
 rtl/contador_16b.sv | 59 +++++
 tb/tb_contador_16b.sv | 138 +++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the contador time-base counter.
package contador_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int DIV_W         = 32;

  typedef logic [CNT_W_DEFAULT-1:0] count_t;

  // True when the default-width count is at its all-ones value
  function automatic logic is_max(input count_t v);
    return (v == '1);
  endfunction

endpackage

// File: rtl/contador_tick_gen.sv
// Clock-enable prescaler: tick pulses once every DIV cycles of CLK.
// DIV=1 degenerates to a constant tick with no state.
module contador_tick_gen
  import contador_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);

  generate
    if (DIV <= 1) begin : g_bypass
      // Every cycle is a count cycle; en only gates the divider flops
      assign tick = en | 1'b1;
    end else begin : g_div
      localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
      logic [DIV_W-1:0] pcnt;

      // Count 0..DIV-1, frozen while en is low
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)    pcnt <= '0;
        else if (en) pcnt <= (pcnt == LAST) ? '0 : pcnt + DIV_W'(1);
      end

      assign tick = en && (pcnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/contador_16b.sv
// Free-running WIDTH-bit up-counter with DIV-cycle prescaler.
// Define CONTADOR_SATURATE_EN to make Q stop at all-ones instead of wrapping.
module contador_16b
  import contador_pkg::*;
#(
  parameter int          WIDTH = CNT_W_DEFAULT,
  parameter int unsigned DIV   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [WIDTH-1:0] Q
);

  logic tick;
  logic tick_en;

  contador_tick_gen #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .en   (tick_en),
    .tick (tick)
  );

`ifdef CONTADOR_SATURATE_EN
  logic at_max;
  logic sat_hold;

  generate
    if (WIDTH == CNT_W_DEFAULT) begin : g_max16
      assign at_max = is_max(count_t'(Q));
    end else begin : g_maxn
      assign at_max = &Q;
    end
  endgenerate

  // Latch saturation so the prescaler can be parked until reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        sat_hold <= 1'b0;
    else if (at_max) sat_hold <= 1'b1;
  end

  assign tick_en = ~sat_hold;

  // Increment on tick, holding once all-ones is reached
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                Q <= '0;
    else if (tick && !at_max) Q <= Q + WIDTH'(1);
  end
`else
  assign tick_en = 1'b1;

  // Increment on tick, wrapping modulo 2^WIDTH
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)     Q <= '0;
    else if (tick) Q <= Q + WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_contador_16b.sv
// Directed bench for contador_16b: four instances (16b/DIV1, 16b/DIV1000,
// 8b/DIV1, 4b/DIV1) share one clock, each with its own reset.
module tb_contador_16b;

  logic        CLK = 1'b0;
  logic        rst16 = 1'b0, rst1k = 1'b0, rst8 = 1'b0, rst4 = 1'b0;
  logic [15:0] q16, q1k;
  logic [7:0]  q8;
  logic [3:0]  q4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  contador_16b #(.WIDTH(16), .DIV(1))    u16 (.CLK(CLK), .RST(rst16), .Q(q16));
  contador_16b #(.WIDTH(16), .DIV(1000)) u1k (.CLK(CLK), .RST(rst1k), .Q(q1k));
  contador_16b #(.WIDTH(8),  .DIV(1))    u8  (.CLK(CLK), .RST(rst8),  .Q(q8));
  contador_16b #(.WIDTH(4),  .DIV(1))    u4  (.CLK(CLK), .RST(rst4),  .Q(q4));

  typedef struct {
    int          sel;   // 0: u16, 1: u8
    int          adv;   // rising edges to run before sampling
    int unsigned exp;
    string       nm;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int unsigned qsel(input int sel);
    return (sel == 0) ? 32'(q16) : 32'(q8);
  endfunction

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].adv);
      check(tbl[i].nm, qsel(tbl[i].sel), tbl[i].exp);
    end
  endtask

  initial begin
    tbl[0] = '{0, 1,     1,     "cnt_first"};
    tbl[1] = '{0, 1,     2,     "cnt_second"};
    tbl[2] = '{0, 48,    50,    "cnt_50"};
    tbl[3] = '{0, 65532, 65535, "wrap_ffff"};
    tbl[4] = '{0, 1,     0,     "wrap_zero"};
    tbl[5] = '{0, 1,     1,     "wrap_one"};
    tbl[6] = '{1, 255,   255,   "w8_ff"};
    tbl[7] = '{1, 1,     0,     "w8_wrap"};
    tbl[8] = '{1, 1,     1,     "w8_one"};

    // Reset held across two clock edges
    #20;
    check("rst_q16", q16, 0);
    check("rst_q1k", q1k, 0);
    check("rst_q8",  q8,  0);
    check("rst_q4",  q4,  0);

    // DIV=1 count after release
    @(negedge CLK); rst16 = 1'b1;
    run_tbl(0, 2);

    // Asynchronous clear between edges, then restart
    rst16 = 1'b0;
    #2;
    check("async_clr", q16, 0);
    @(negedge CLK); @(negedge CLK);
    check("async_hold", q16, 0);
    rst16 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("restart", q16, k);
    end

    // Wrap-around at 16 bits
    run_tbl(3, 5);
    rst16 = 1'b0;

    // 8-bit width
    @(negedge CLK); rst8 = 1'b1;
    run_tbl(6, 8);
    rst8 = 1'b0;

    // 4-bit: saturates or wraps depending on build
    @(negedge CLK); rst4 = 1'b1;
    step(15);
    check("w4_max", q4, 15);
    step(20);
`ifdef CONTADOR_SATURATE_EN
    check("w4_after20", q4, 15);
`else
    check("w4_after20", q4, 3);
`endif
    rst4 = 1'b0;
    #2;
    check("w4_rst", q4, 0);

    // Prescaler DIV=1000
    @(negedge CLK); rst1k = 1'b1;
    step(999);
    check("div_e999", q1k, 0);
    step(1);
    check("div_e1000", q1k, 1);
    step(1000);
    check("div_e2000", q1k, 2);
    step(500);
    check("div_e2500", q1k, 2);
    check("div_pcnt500", u1k.u_tick.g_div.pcnt, 500);
    rst1k = 1'b0;
    #2;
    check("div_rst_q", q1k, 0);
    check("div_rst_pcnt", u1k.u_tick.g_div.pcnt, 0);
    @(negedge CLK); @(negedge CLK);
    rst1k = 1'b1;
    step(999);
    check("div_rel_e999", q1k, 0);
    step(1);
    check("div_rel_e1000", q1k, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
